reservation_station: RTL and testbench

RESERVATION_STATION -- requirements
Module: reservation_station

---
 rtl/reservation_station_pkg.sv | 43 ++++
 rtl/reg_status_table.sv | 39 +++
 rtl/reservation_station.sv | 133 +++++++++++++
 tb/tb_reservation_station.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/reservation_station_pkg.sv
// reservation_station_pkg: shared types, tag bases and ALU helpers for the reservation station.
package reservation_station_pkg;
  localparam int WORD_W = 32;
  localparam int REG_W = 6;
  localparam int NREGS = 1 << REG_W;
  typedef logic [WORD_W-1:0] word_t;
  typedef logic [REG_W-1:0] reg_t;
  typedef logic [7:0] tag_t;
  typedef enum logic [1:0] {UNIT_LW = 2'b00, UNIT_SW = 2'b01, UNIT_ADD = 2'b10, UNIT_MUL = 2'b11} unit_e;
  localparam tag_t TAG_NONE = 8'h00;
  localparam tag_t TAG_ADD = 8'hA0;
  localparam tag_t TAG_MUL = 8'hC0;
  typedef struct packed {
    logic  busy;
    tag_t  qa;
    tag_t  qb;
    word_t va;
    word_t vb;
  } entry_t;
  function automatic word_t alu_add(word_t a, word_t b);
    return a + b;
  endfunction
  function automatic word_t alu_mul(word_t a, word_t b);
    return word_t'($signed(a) * $signed(b));
  endfunction
  function automatic logic is_ready(entry_t e);
    return e.busy && e.qa == TAG_NONE && e.qb == TAG_NONE;
  endfunction
  // A waiting operand picks up a broadcast result whose tag it is holding.
  function automatic entry_t snoop(entry_t e, logic v, tag_t t, word_t d);
    entry_t r;
    r = e;
    if (e.busy && v && e.qa == t) begin
      r.qa = TAG_NONE;
      r.va = d;
    end
    if (e.busy && v && e.qb == t) begin
      r.qb = TAG_NONE;
      r.vb = d;
    end
    return r;
  endfunction
endpackage

// File: rtl/reg_status_table.sv
// reg_status_table: per-register pending-producer tags with operand/debug reads, dispatch write and CDB clear.
module reg_status_table
  import reservation_station_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] ra_addr,
  input  logic [REG_W-1:0] rb_addr,
  input  logic [REG_W-1:0] dbg_addr,
  output logic [7:0]       ra_tag,
  output logic [7:0]       rb_tag,
  output logic [7:0]       dbg_tag,
  input  logic             we,
  input  logic [REG_W-1:0] waddr,
  input  logic [7:0]       wtag,
  input  logic             clr_valid,
  input  logic [7:0]       clr_tag,
  output logic [NREGS-1:0] clr_hit
);
  tag_t tag_q [NREGS];
  tag_t tag_d [NREGS];
  assign ra_tag = tag_q[ra_addr];
  assign rb_tag = tag_q[rb_addr];
  assign dbg_tag = tag_q[dbg_addr];
  // A dispatch to a register being cleared this edge keeps its new tag.
  always_comb begin
    tag_d = tag_q;
    clr_hit = '0;
    for (int i = 0; i < NREGS; i++) begin
      clr_hit[i] = clr_valid && tag_q[i] == clr_tag;
      tag_d[i] = clr_hit[i] ? TAG_NONE : tag_q[i];
    end
    if (we) tag_d[waddr] = wtag;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tag_q <= '{default: TAG_NONE};
    else tag_q <= tag_d;
  end
endmodule

// File: rtl/reservation_station.sv
// reservation_station: add/mul reservation stations with register file, RRS table and a one-result CDB.
// Define MUL_UNIT_EN to enable the mul station and multiplier; otherwise unit=11 is rejected.
module reservation_station
  import reservation_station_pkg::*;
#(
  parameter int ADD_DEPTH = 4,
  parameter int MUL_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [1:0]        unit,
  input  logic [REG_W-1:0]  reg1,
  input  logic [REG_W-1:0]  reg2,
  input  logic [REG_W-1:0]  reg3,
  input  logic              hasimm,
  input  logic [WORD_W-1:0] imm,
  output logic              out,
  input  logic              rf_we,
  input  logic [REG_W-1:0]  rf_waddr,
  input  logic [WORD_W-1:0] rf_wdata,
  input  logic [REG_W-1:0]  rd_addr,
  output logic [WORD_W-1:0] rd_data,
  output logic [7:0]        rd_tag,
  output logic              cdb_valid,
  output logic [7:0]        cdb_tag,
  output logic [WORD_W-1:0] cdb_data
);
`ifdef MUL_UNIT_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif
  entry_t add_q [ADD_DEPTH];
  entry_t add_d [ADD_DEPTH];
  entry_t mul_q [MUL_DEPTH];
  entry_t mul_d [MUL_DEPTH];
  word_t rf_q [NREGS];
  word_t rf_d [NREGS];
  logic out_q, out_d, cdb_valid_q, cdb_valid_d;
  tag_t cdb_tag_q, cdb_tag_d, ta, tb, new_tag;
  word_t cdb_data_q, cdb_data_d;
  logic [NREGS-1:0] cdb_hit;
  logic alloc, issued, want_add, want_mul;
  entry_t new_e;
  reg_status_table u_rrs (
    .clk(clk), .rst_n(rst_n),
    .ra_addr(reg2), .rb_addr(reg3), .dbg_addr(rd_addr),
    .ra_tag(ta), .rb_tag(tb), .dbg_tag(rd_tag),
    .we(alloc), .waddr(reg1), .wtag(new_tag),
    .clr_valid(cdb_valid_q), .clr_tag(cdb_tag_q), .clr_hit(cdb_hit)
  );
  assign want_add = enable && unit == UNIT_ADD;
  assign want_mul = enable && unit == UNIT_MUL && MUL_EN;
  // Operands forward from the CDB when their producer is broadcasting at this edge.
  always_comb begin
    new_e = '0;
    new_e.busy = 1'b1;
    new_e.qa = (cdb_valid_q && ta == cdb_tag_q) ? TAG_NONE : ta;
    new_e.va = ta == TAG_NONE ? rf_q[reg2] : cdb_data_q;
    new_e.qb = (hasimm || (cdb_valid_q && tb == cdb_tag_q)) ? TAG_NONE : tb;
    new_e.vb = hasimm ? imm : tb == TAG_NONE ? rf_q[reg3] : cdb_data_q;
  end
  always_comb begin
    cdb_valid_d = 1'b0;
    cdb_tag_d = TAG_NONE;
    cdb_data_d = '0;
    issued = 1'b0;
    alloc = 1'b0;
    new_tag = TAG_NONE;
    for (int i = 0; i < ADD_DEPTH; i++) add_d[i] = snoop(add_q[i], cdb_valid_q, cdb_tag_q, cdb_data_q);
    for (int i = 0; i < MUL_DEPTH; i++) mul_d[i] = snoop(mul_q[i], cdb_valid_q, cdb_tag_q, cdb_data_q);
    for (int i = 0; i < ADD_DEPTH; i++)
      if (!issued && is_ready(add_q[i])) begin
        issued = 1'b1;
        cdb_valid_d = 1'b1;
        cdb_tag_d = TAG_ADD + tag_t'(i);
        cdb_data_d = alu_add(add_q[i].va, add_q[i].vb);
        add_d[i].busy = 1'b0;
      end
    for (int i = 0; i < MUL_DEPTH; i++)
      if (MUL_EN && !issued && is_ready(mul_q[i])) begin
        issued = 1'b1;
        cdb_valid_d = 1'b1;
        cdb_tag_d = TAG_MUL + tag_t'(i);
        cdb_data_d = alu_mul(mul_q[i].va, mul_q[i].vb);
        mul_d[i].busy = 1'b0;
      end
    // Free-ness is judged on current state, so an entry issuing now is not reused this edge.
    for (int i = 0; i < ADD_DEPTH; i++)
      if (want_add && !alloc && !add_q[i].busy) begin
        alloc = 1'b1;
        add_d[i] = new_e;
        new_tag = TAG_ADD + tag_t'(i);
      end
    for (int i = 0; i < MUL_DEPTH; i++)
      if (want_mul && !alloc && !mul_q[i].busy) begin
        alloc = 1'b1;
        mul_d[i] = new_e;
        new_tag = TAG_MUL + tag_t'(i);
      end
    out_d = alloc;
  end
  always_comb begin
    rf_d = rf_q;
    if (rf_we) rf_d[rf_waddr] = rf_wdata;
    for (int j = 0; j < NREGS; j++) rf_d[j] = cdb_hit[j] ? cdb_data_q : rf_d[j];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      add_q <= '{default: '0};
      mul_q <= '{default: '0};
      rf_q <= '{default: '0};
      out_q <= 1'b0;
      cdb_valid_q <= 1'b0;
      cdb_tag_q <= TAG_NONE;
      cdb_data_q <= '0;
    end else begin
      add_q <= add_d;
      mul_q <= mul_d;
      rf_q <= rf_d;
      out_q <= out_d;
      cdb_valid_q <= cdb_valid_d;
      cdb_tag_q <= cdb_tag_d;
      cdb_data_q <= cdb_data_d;
    end
  end
  assign out = out_q;
  assign cdb_valid = cdb_valid_q;
  assign cdb_tag = cdb_tag_q;
  assign cdb_data = cdb_data_q;
  assign rd_data = rf_q[rd_addr];
endmodule

// File: tb/tb_reservation_station.sv
// tb_reservation_station: table-driven directed checks of dispatch, CDB, capacity, reset and (with MUL_UNIT_EN) mul.
module tb_reservation_station;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b0, hasimm = 1'b0, rf_we = 1'b0;
  logic [1:0] unit = '0;
  logic [5:0] reg1 = '0, reg2 = '0, reg3 = '0, rf_waddr = '0, rd_addr = '0;
  logic [31:0] imm = '0, rf_wdata = '0;
  logic out, cdb_valid;
  logic [31:0] rd_data, cdb_data;
  logic [7:0] rd_tag, cdb_tag;
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  reservation_station dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .unit(unit),
    .reg1(reg1), .reg2(reg2), .reg3(reg3), .hasimm(hasimm), .imm(imm),
    .out(out), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_tag(rd_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data)
  );

  typedef struct {
    logic en; logic [1:0] unit; logic [5:0] r1, r2, r3; logic hi; logic [31:0] imm;
    logic we; logic [5:0] wa; logic [31:0] wd; logic [5:0] rda;
    logic e_out, e_cv; logic [7:0] e_tag; logic [31:0] e_data; logic [7:0] e_rtag; logic [31:0] e_rdata;
  } vec_t;
  vec_t vq[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic void v(input int en, input int u, input int r1, input int r2, input int r3,
                            input int hi, input int im, input int we, input int wa, input int wd,
                            input int rda, input int eo, input int ecv, input int etag,
                            input int edata, input int ertag, input int erdata);
    vec_t x;
    x.en = 1'(en); x.unit = 2'(u); x.r1 = 6'(r1); x.r2 = 6'(r2); x.r3 = 6'(r3);
    x.hi = 1'(hi); x.imm = 32'(im); x.we = 1'(we); x.wa = 6'(wa); x.wd = 32'(wd); x.rda = 6'(rda);
    x.e_out = 1'(eo); x.e_cv = 1'(ecv); x.e_tag = 8'(etag); x.e_data = 32'(edata);
    x.e_rtag = 8'(ertag); x.e_rdata = 32'(erdata);
    vq.push_back(x);
  endfunction

  function automatic void idle(input int rda, input int ecv, input int etag, input int edata,
                               input int ertag, input int erdata);
    v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, rda, 0, ecv, etag, edata, ertag, erdata);
  endfunction

  task automatic run_table(input string tbl);
    foreach (vq[i]) begin
      enable = vq[i].en; unit = vq[i].unit; reg1 = vq[i].r1; reg2 = vq[i].r2; reg3 = vq[i].r3;
      hasimm = vq[i].hi; imm = vq[i].imm; rf_we = vq[i].we; rf_waddr = vq[i].wa;
      rf_wdata = vq[i].wd; rd_addr = vq[i].rda;
      @(posedge clk);
      #1;
      chk($sformatf("%s[%0d] out", tbl, i), 32'(out), 32'(vq[i].e_out));
      chk($sformatf("%s[%0d] cdb_valid", tbl, i), 32'(cdb_valid), 32'(vq[i].e_cv));
      if (vq[i].e_cv) begin
        chk($sformatf("%s[%0d] cdb_tag", tbl, i), 32'(cdb_tag), 32'(vq[i].e_tag));
        chk($sformatf("%s[%0d] cdb_data", tbl, i), cdb_data, vq[i].e_data);
      end
      chk($sformatf("%s[%0d] rd_tag", tbl, i), 32'(rd_tag), 32'(vq[i].e_rtag));
      chk($sformatf("%s[%0d] rd_data", tbl, i), rd_data, vq[i].e_rdata);
    end
    vq.delete();
    enable = 1'b0; rf_we = 1'b0;
  endtask

  initial begin
    #12;
    chk("reset out", 32'(out), 32'd0);
    chk("reset cdb_valid", 32'(cdb_valid), 32'd0);
    for (int a = 0; a < 4; a++) begin
      rd_addr = 6'(a);
      #1;
      chk($sformatf("reset rd_tag r%0d", a), 32'(rd_tag), 32'd0);
      chk($sformatf("reset rd_data r%0d", a), rd_data, 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // basic add, reserved units, fill-to-capacity chain, drain, CDB vs rf_we, dispatch-wins-RRS
    v(0, 0, 0, 0, 0, 0, 0, 1, 1, 5, 1, 0, 0, 0, 0, 0, 5);
    v(0, 0, 0, 0, 0, 0, 0, 1, 2, 7, 2, 0, 0, 0, 0, 0, 7);
    v(1, 2, 3, 1, 2, 0, 0, 0, 0, 0, 3, 1, 0, 0, 0, 'hA0, 0);
    idle(3, 1, 'hA0, 12, 'hA0, 0);
    idle(3, 0, 0, 0, 0, 12);
    v(1, 0, 3, 1, 2, 0, 0, 0, 0, 0, 3, 0, 0, 0, 0, 0, 12);
    v(1, 1, 3, 1, 2, 0, 0, 0, 0, 0, 3, 0, 0, 0, 0, 0, 12);
    v(1, 2, 10, 1, 2, 0, 0, 0, 0, 0, 10, 1, 0, 0, 0, 'hA0, 0);
    v(1, 2, 11, 10, 0, 1, 1, 0, 0, 0, 11, 1, 1, 'hA0, 12, 'hA1, 0);
    v(1, 2, 12, 11, 0, 1, 1, 0, 0, 0, 10, 1, 0, 0, 0, 0, 12);
    v(1, 2, 13, 12, 0, 1, 1, 0, 0, 0, 13, 1, 1, 'hA1, 13, 'hA2, 0);
    v(1, 2, 14, 13, 0, 1, 1, 0, 0, 0, 11, 1, 0, 0, 0, 0, 13);
    v(1, 2, 15, 14, 0, 1, 1, 0, 0, 0, 15, 1, 1, 'hA0, 14, 'hA3, 0);
    v(1, 2, 16, 15, 0, 1, 1, 0, 0, 0, 16, 1, 0, 0, 0, 'hA0, 0);
    v(1, 2, 17, 16, 0, 1, 1, 0, 0, 0, 17, 0, 1, 'hA2, 15, 0, 0);
    idle(13, 0, 0, 0, 0, 15);
    idle(14, 1, 'hA1, 16, 'hA1, 0);
    idle(14, 0, 0, 0, 0, 16);
    idle(15, 1, 'hA3, 17, 'hA3, 0);
    idle(15, 0, 0, 0, 0, 17);
    idle(16, 1, 'hA0, 18, 'hA0, 0);
    v(1, 2, 16, 1, 2, 0, 0, 1, 16, 999, 16, 1, 0, 0, 0, 'hA0, 18);
    idle(16, 1, 'hA0, 12, 'hA0, 18);
    idle(16, 0, 0, 0, 0, 12);
    run_table("main");

    // reset pulsed while two adds are in flight
    v(1, 2, 20, 1, 2, 0, 0, 0, 0, 0, 20, 1, 0, 0, 0, 'hA0, 0);
    v(1, 2, 21, 20, 20, 0, 0, 0, 0, 0, 21, 1, 1, 'hA0, 12, 'hA1, 0);
    run_table("pre_rst");
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid-reset cdb_valid", 32'(cdb_valid), 32'd0);
    chk("mid-reset out", 32'(out), 32'd0);
    chk("mid-reset rd_tag r21", 32'(rd_tag), 32'd0);
    rd_addr = 6'd1;
    #1;
    chk("mid-reset rd_data r1", rd_data, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    v(1, 2, 22, 1, 0, 1, 4, 0, 0, 0, 22, 1, 0, 0, 0, 'hA0, 0);
    idle(22, 1, 'hA0, 4, 'hA0, 0);
    run_table("post_rst");

`ifdef MUL_UNIT_EN
    v(0, 0, 0, 0, 0, 0, 0, 1, 1, 5, 1, 0, 0, 0, 0, 0, 5);
    v(1, 3, 4, 1, 0, 1, -3, 0, 0, 0, 4, 1, 0, 0, 0, 'hC0, 0);
    idle(4, 1, 'hC0, 32'hFFFFFFF1, 'hC0, 0);
    v(1, 2, 5, 4, 4, 0, 0, 0, 0, 0, 4, 1, 0, 0, 0, 0, 32'hFFFFFFF1);
    idle(5, 1, 'hA0, 32'hFFFFFFE2, 'hA0, 0);
    idle(5, 0, 0, 0, 0, 32'hFFFFFFE2);
    v(1, 2, 6, 1, 0, 1, 1, 0, 0, 0, 6, 1, 0, 0, 0, 'hA0, 0);
    v(1, 3, 7, 6, 0, 1, 3, 0, 0, 0, 7, 1, 1, 'hA0, 6, 'hC0, 0);
    v(1, 2, 8, 6, 0, 1, 2, 0, 0, 0, 6, 1, 0, 0, 0, 0, 6);
    idle(8, 1, 'hA0, 8, 'hA0, 0);
    idle(7, 1, 'hC0, 18, 'hC0, 0);
    idle(7, 0, 0, 0, 0, 18);
    run_table("mul");
`else
    v(1, 3, 4, 1, 0, 1, -3, 0, 0, 0, 4, 0, 0, 0, 0, 0, 0);
    idle(4, 0, 0, 0, 0, 0);
    run_table("nomul");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
